// File: rtl/seq_mul.sv
// -----------------------------------------------------------------------------
// seq_mul
//
// Iterative shift-and-add integer multiplier. One partial product is added per
// clock, so a WIDTH x WIDTH multiply takes WIDTH+1 edges from the accepting
// edge to the done pulse. Signed operation is done on magnitudes; the sign of
// the result is applied in a single final step.
//
// Ports:
//   clk    in   1        clock, all state updates on the rising edge
//   rst_n  in   1        synchronous active-low reset
//   start  in   1        request, sampled only while busy=0
//   sgn    in   1        1 = two's-complement operands, 0 = unsigned
//   a      in   WIDTH    multiplicand, sampled with start
//   b      in   WIDTH    multiplier, sampled with start
//   busy   out  1        high while an operation is in progress
//   done   out  1        one-cycle pulse, p valid from this cycle
//   p      out  2*WIDTH  product, held until the next completion or reset
// -----------------------------------------------------------------------------
module seq_mul #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 sgn,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   p
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [2*WIDTH-1:0]   mcand_q, mcand_d;    // multiplicand, shifted left each step
    logic [WIDTH-1:0]     mplier_q, mplier_d;  // multiplier, shifted right each step
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic                 neg_q, neg_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   p_q, p_d;
    logic                 done_q, done_d;

    // Operand magnitudes. For the most negative value the negation wraps back
    // to 2^(WIDTH-1), which is exactly the correct unsigned magnitude.
    logic [WIDTH-1:0]     abs_a;
    logic [WIDTH-1:0]     abs_b;

    always_comb begin
        abs_a = (sgn && a[WIDTH-1]) ? (~a + 1'b1) : a;
        abs_b = (sgn && b[WIDTH-1]) ? (~b + 1'b1) : b;
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            neg_q    <= 1'b0;
            cnt_q    <= '0;
            p_q      <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            neg_q    <= neg_d;
            cnt_q    <= cnt_d;
            p_q      <= p_d;
            done_q   <= done_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        neg_d    = neg_q;
        cnt_d    = cnt_q;
        p_d      = p_q;
        done_d   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    mcand_d  = {{WIDTH{1'b0}}, abs_a};
                    mplier_d = abs_b;
                    neg_d    = sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
                    acc_d    = '0;
                    cnt_d    = CW'(WIDTH);
                    state_d  = S_RUN;
                end
            end

            S_RUN: begin
                if (mplier_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end
                mplier_d = mplier_q >> 1;
                mcand_d  = mcand_q << 1;
                cnt_d    = cnt_q - CW'(1);
                // cnt_q == 1 means this edge performs the last iteration.
                if (cnt_q == CW'(1)) begin
                    state_d = S_FIX;
                end
            end

            S_FIX: begin
                // Negating a zero accumulator yields zero, so no special case.
                p_d     = neg_q ? (~acc_q + 1'b1) : acc_q;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy = (state_q != S_IDLE);
    assign done = done_q;
    assign p    = p_q;

endmodule

// File: tb/tb_seq_mul.sv
// -----------------------------------------------------------------------------
// tb_seq_mul
//
// Directed bench for seq_mul (WIDTH=32). A behavioural model computes each
// product with plain 64-bit arithmetic and tracks the request/latency contract
// by counting edges; a compare process checks busy/done/p against it every
// cycle. Each directed transaction also checks literal, hand-computed values.
// -----------------------------------------------------------------------------
module tb_seq_mul;

    localparam int W = 32;

    logic            clk;
    logic            rst_n;
    logic            start;
    logic            sgn;
    logic [W-1:0]    a;
    logic [W-1:0]    b;
    logic            busy;
    logic            done;
    logic [2*W-1:0]  p;

    int checks   = 0;
    int failures = 0;

    seq_mul #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .sgn   (sgn),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .p     (p)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------ model
    function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] x,
                                               input logic [W-1:0] y,
                                               input logic s);
        logic signed [2*W-1:0] sx;
        logic signed [2*W-1:0] sy;
        logic [2*W-1:0]        ux;
        logic [2*W-1:0]        uy;
        sx = {{W{x[W-1]}}, x};
        sy = {{W{y[W-1]}}, y};
        ux = {{W{1'b0}}, x};
        uy = {{W{1'b0}}, y};
        if (s) return sx * sy;
        return ux * uy;
    endfunction

    logic            m_busy = 1'b0;
    logic            m_done = 1'b0;
    logic [2*W-1:0]  m_p    = '0;
    logic [2*W-1:0]  m_pend = '0;
    int              m_cnt  = 0;   // edges elapsed since the accepting edge

    always @(posedge clk) begin
        m_done <= 1'b0;
        if (!rst_n) begin
            m_busy <= 1'b0;
            m_p    <= '0;
            m_cnt  <= 0;
        end else if (m_busy) begin
            if (m_cnt == W) begin
                m_busy <= 1'b0;
                m_done <= 1'b1;
                m_p    <= m_pend;
            end else begin
                m_cnt <= m_cnt + 1;
            end
        end else if (start) begin
            m_busy <= 1'b1;
            m_cnt  <= 0;
            m_pend <= ref_mul(a, b, sgn);
        end
    end

    // --------------------------------------------------------------- checkers
    task automatic check64(input string nm, input logic [2*W-1:0] act,
                           input logic [2*W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic check_int(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    bit cmp_en = 1'b0;

    always @(negedge clk) begin
        if (cmp_en) begin
            check64("cyc_busy", {63'd0, busy}, {63'd0, m_busy});
            check64("cyc_done", {63'd0, done}, {63'd0, m_done});
            check64("cyc_p", p, m_p);
        end
    end

    // -------------------------------------------------------------- stimulus
    task automatic run_op(input string nm, input logic [W-1:0] ta,
                          input logic [W-1:0] tb_v, input logic ts,
                          input logic [2*W-1:0] exp_p);
        int k;
        int bcnt;
        int seen;
        @(negedge clk);
        a = ta; b = tb_v; sgn = ts; start = 1'b1;
        k = 0; bcnt = 0; seen = 0;
        while (seen == 0 && k < 60) begin
            @(negedge clk);
            k++;
            if (k == 1) start = 1'b0;
            if (busy) bcnt++;
            if (done) seen = 1;
        end
        check_int({nm, "_done_seen"}, seen, 1);
        check_int({nm, "_latency"}, k - 1, W + 1);
        check_int({nm, "_busy_cycles"}, bcnt, W + 1);
        check64({nm, "_p"}, p, exp_p);
        $display("op %s a=%h b=%h sgn=%0d p=%h", nm, ta, tb_v, ts, p);
    endtask

    initial begin
        int k;
        int dcnt;
        int seen;

        rst_n = 1'b0; start = 1'b0; sgn = 1'b0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        cmp_en = 1'b1;
        check64("reset_busy", {63'd0, busy}, 64'd0);
        check64("reset_done", {63'd0, done}, 64'd0);
        check64("reset_p", p, 64'd0);
        $display("reset busy=%0d done=%0d p=%h", busy, done, p);
        rst_n = 1'b1;

        // Literal pins on the model itself
        check64("model_u11x5", ref_mul(32'd11, 32'd5, 1'b0), 64'd55);
        check64("model_s_m10x5", ref_mul(32'hFFFFFFF6, 32'd5, 1'b1),
                64'hFFFFFFFFFFFFFFCE);

        run_op("u5x0", 32'd5, 32'd0, 1'b0, 64'd0);
        run_op("u0x5", 32'd0, 32'd5, 1'b0, 64'd0);
        run_op("u11x5", 32'd11, 32'd5, 1'b0, 64'd55);
        run_op("u_max_sq", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0,
               64'hFFFFFFFE00000001);
        run_op("s_m10x5", 32'hFFFFFFF6, 32'd5, 1'b1, 64'hFFFFFFFFFFFFFFCE);
        run_op("s_m7xm3", 32'hFFFFFFF9, 32'hFFFFFFFD, 1'b1, 64'd21);
        run_op("s_min_sq", 32'h80000000, 32'h80000000, 1'b1,
               64'h4000000000000000);
        run_op("s_min_x1", 32'h80000000, 32'd1, 1'b1, 64'hFFFFFFFF80000000);
        run_op("s_0xm5", 32'd0, 32'hFFFFFFFB, 1'b1, 64'd0);

        // Busy rejection: second request at edge 10 must be dropped
        @(negedge clk);
        a = 32'd11; b = 32'd5; sgn = 1'b0; start = 1'b1;
        k = 0; seen = 0;
        while (seen == 0 && k < 60) begin
            @(negedge clk);
            k++;
            if (k == 1) start = 1'b0;
            if (k == 10) begin a = 32'd3; b = 32'd3; start = 1'b1; end
            if (k == 11) start = 1'b0;
            if (done) seen = 1;
        end
        check_int("busyrej_done_seen", seen, 1);
        check_int("busyrej_latency", k - 1, W + 1);
        check64("busyrej_p", p, 64'd55);
        dcnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        check_int("busyrej_extra_done", dcnt, 0);
        check64("busyrej_p_held", p, 64'd55);
        $display("op busyrej p=%h extra_done=%0d", p, dcnt);

        // Back-to-back: start held high through the done cycle
        @(negedge clk);
        a = 32'd6; b = 32'd7; sgn = 1'b0; start = 1'b1;
        k = 0; seen = 0;
        while (seen == 0 && k < 60) begin
            @(negedge clk);
            k++;
            if (done) seen = 1;
        end
        check_int("b2b_first_seen", seen, 1);
        check_int("b2b_first_latency", k - 1, W + 1);
        check64("b2b_first_p", p, 64'd42);
        $display("op b2b_first p=%h", p);
        a = 32'd2; b = 32'd9;
        k = 0; seen = 0;
        while (seen == 0 && k < 60) begin
            @(negedge clk);
            k++;
            if (k == 1) start = 1'b0;
            if (done) seen = 1;
        end
        check_int("b2b_second_seen", seen, 1);
        check_int("b2b_second_latency", k - 1, W + 1);
        check64("b2b_second_p", p, 64'd18);
        $display("op b2b_second p=%h", p);

        // Reset mid-operation at edge 15
        @(negedge clk);
        a = 32'd11; b = 32'd5; sgn = 1'b0; start = 1'b1;
        dcnt = 0;
        for (int j = 1; j <= 60; j++) begin
            @(negedge clk);
            if (j == 1) start = 1'b0;
            if (j == 15) rst_n = 1'b0;
            if (j == 16) begin
                rst_n = 1'b1;
                check64("midrst_busy", {63'd0, busy}, 64'd0);
                check64("midrst_p", p, 64'd0);
                check64("midrst_done", {63'd0, done}, 64'd0);
            end
            if (done) dcnt++;
        end
        check_int("midrst_no_done", dcnt, 0);
        $display("op midrst busy=%0d p=%h done_pulses=%0d", busy, p, dcnt);
        run_op("after_rst_4x4", 32'd4, 32'd4, 1'b0, 64'd16);

        repeat (3) @(negedge clk);
        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seq_mul.md
# seq_mul

Iterative shift-and-add integer multiplier: the companion to the integer divider block, giving the ALU the inverse operation over the same operand width. It accepts two WIDTH-bit operands with a start strobe, runs one partial product per clock, and returns a full 2·WIDTH-bit product with a one-cycle done pulse. A mode input selects unsigned or two's-complement signed operation, matching the divider's udiv/sdiv split in a single block.

## Interface

Parameters:
- WIDTH, default 32, operand width in bits; product is 2·WIDTH bits.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  reset, synchronous and active-low.
- start  input  1  request; sampled only when busy=0.
- sgn  input  1  1 = signed two's-complement operands, 0 = unsigned; sampled with start.
- a  input  WIDTH  multiplicand; sampled with start.
- b  input  WIDTH  multiplier; sampled with start.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse; p is valid from this cycle.
- p  output  2·WIDTH  product; held until the next completion or reset.

## Operation

- States: IDLE, RUN, FIX.
- IDLE: busy=0. On an edge with start=1, latch the operands:
  - sgn=1: store |a| and |b| as WIDTH-bit unsigned values, and store neg = a[MSB] ^ b[MSB].
  - sgn=0: store a and b raw, with neg=0.
  - Clear the accumulator, load the counter with WIDTH, and go to RUN.
- RUN: each edge, if the multiplier LSB is 1, add the multiplicand at the current shift into the 2·WIDTH accumulator. Then shift the multiplier right and the multiplicand left, and decrement the counter. After the WIDTH-th iteration, go to FIX.
- FIX: on one edge, write p = neg ? −acc : acc (two's complement over 2·WIDTH bits), set done=1 and busy=0, and go to IDLE.
- Width rules:
  - |−2^(WIDTH−1)| = 2^(WIDTH−1) fits unsigned in WIDTH bits. No overflow is possible; the product always fits in 2·WIDTH bits.
  - A zero operand is not special-cased: it runs the full latency and gives p=0 with neg applied (−0 = 0).
- start while busy=1 is ignored. Inputs a, b and sgn may change freely after the accepting edge.
- Back-to-back: start high in the done cycle (busy=0) is accepted on the next edge.
- Reset (rst_n=0 at any edge, including mid-RUN or in FIX) puts the block in IDLE with busy=0, done=0 and p=0. The in-flight operation is discarded with no done pulse. Reset takes priority over start.

## Timing

- Reset values: busy=0, done=0, p=0; internal state IDLE, counter 0.
- Let edge 0 be the accepting edge (start=1, busy=0).
- busy=1 after edges 0 through W, so busy is high for WIDTH+1 cycles.
- At edge WIDTH+1: p is updated, done=1 and busy=0. The latency from the accepting edge to the done pulse is WIDTH+1 edges (33 for WIDTH=32).
- At edge WIDTH+2: done=0. p is held.
- done is never high for two consecutive cycles. done and busy are never high together.
- p changes only at FIX edges and at reset.

## Test plan

- Unsigned 5 × 0, and 0 × 5: p=0, done exactly 33 edges after the accepting edge, busy high for 33 cycles.
- Unsigned 11 × 5 → p=55. Unsigned 0xFFFFFFFF × 0xFFFFFFFF → p=0xFFFFFFFE00000001.
- Signed −10 × 5 → p=0xFFFFFFFFFFFFFFCE. Signed −7 × −3 → p=21. Signed 0x80000000 × 0x80000000 → p=0x4000000000000000. Signed 0x80000000 × 1 → p=0xFFFFFFFF80000000.
- Busy rejection: start 11 × 5 and, at edge 10, pulse start with 3 × 3 → only one done pulse, p=55, and the second request is lost.
- Back-to-back: hold start high with 6 × 7 then 2 × 9 presented in the done cycle → p=42, then p=18, 33 edges later.
- Reset mid-operation: start 11 × 5, drive rst_n=0 at edge 15 for one edge → busy=0, p=0, no done pulse. A following start of 4 × 4 gives p=16 with full latency.
